vector_ex_wb_buffer: RTL and testbench

- Two-entry elastic buffer between the vector execute stage (per-lane FP multiplier/ALU results plus per-lane C/V/N flags) and vector register writeback.
- Decouples execute from writeback stalls.
- Applies the lane mask: zeroes the results of disabled lanes and reduces per-lane flags to per-instruction summary flags.
- Maintains a sticky overflow bit and a saturating count of overflowed lanes for status readout.

---
 rtl/vector_ex_wb_buffer.sv | 129 ++++++++++++
 tb/tb_vector_ex_wb_buffer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_ex_wb_buffer.sv
// Two-entry elastic buffer between the vector execute stage and vector register writeback.
// It masks disabled lanes when an entry is accepted, reduces the lane flags, and tracks overflow status.
module vector_ex_wb_buffer #(
  parameter int WIDTH = 8,
  parameter int LANES = 8,
  parameter int RDW   = 4,
  parameter int CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  in_result,
  input  logic [LANES-1:0]             in_C,
  input  logic [LANES-1:0]             in_V,
  input  logic [LANES-1:0]             in_N,
  input  logic [LANES-1:0]             in_mask,
  input  logic [RDW-1:0]               in_rd,
  input  logic                         in_we,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  out_result,
  output logic [RDW-1:0]               out_rd,
  output logic                         out_we,
  output logic                         out_C,
  output logic                         out_V,
  output logic                         out_N,
  input  logic                         sticky_clr,
  output logic                         sticky_V,
  output logic [CNTW-1:0]              ovf_count
);

  localparam int PCW = $clog2(LANES + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready and out_valid depend only on the fill count, never on the other side's inputs.

  logic [LANES-1:0][WIDTH-1:0] res_q [2];
  logic [RDW-1:0]              rd_q  [2];
  logic                        we_q  [2];
  logic                        c_q   [2];
  logic                        v_q   [2];
  logic                        n_q   [2];
  logic                        rptr;
  logic                        wptr;
  logic [1:0]                  count;

  logic                        push;
  logic                        pop;
  logic                        accept;
  logic [LANES-1:0][WIDTH-1:0] masked_result;
  logic [LANES-1:0]            masked_v;
  logic [PCW-1:0]              v_pop;
  logic [CNTW:0]               cnt_sum;
  logic [CNTW-1:0]             cnt_next;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // A push offered in a flush cycle is dropped and leaves the status untouched.
  assign accept    = push & ~flush;
  assign masked_v  = in_V & in_mask;

  always_comb begin
    masked_result = '0;
    v_pop         = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_mask[i]) masked_result[i] = in_result[i];
      v_pop = v_pop + PCW'(masked_v[i]);
    end
    cnt_sum  = {1'b0, ovf_count} + (CNTW+1)'(v_pop);
    cnt_next = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
      for (int e = 0; e < 2; e++) begin
        res_q[e] <= '0;
        rd_q[e]  <= '0;
        we_q[e]  <= 1'b0;
        c_q[e]   <= 1'b0;
        v_q[e]   <= 1'b0;
        n_q[e]   <= 1'b0;
      end
    end else if (flush) begin
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        res_q[wptr] <= masked_result;
        rd_q[wptr]  <= in_rd;
        we_q[wptr]  <= in_we;
        c_q[wptr]   <= |(in_C & in_mask);
        v_q[wptr]   <= |masked_v;
        n_q[wptr]   <= |(in_N & in_mask);
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_V  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (accept && |masked_v) sticky_V <= 1'b1;
      else if (sticky_clr)     sticky_V <= 1'b0;
      if (accept) ovf_count <= cnt_next;
    end
  end

  assign out_result = res_q[rptr];
  assign out_rd     = rd_q[rptr];
  assign out_we     = we_q[rptr];
  assign out_C      = c_q[rptr];
  assign out_V      = v_q[rptr];
  assign out_N      = n_q[rptr];

endmodule

// File: tb/tb_vector_ex_wb_buffer.sv
// Bench for vector_ex_wb_buffer: a reference model of the queue and the overflow status, plus directed scenarios.
module tb_vector_ex_wb_buffer;

  localparam int WIDTH = 8;
  localparam int LANES = 8;
  localparam int RDW   = 4;
  localparam int CNTW  = 16;
  localparam int W     = LANES*WIDTH + RDW + 4;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][WIDTH-1:0] in_result;
  logic [LANES-1:0]            in_C;
  logic [LANES-1:0]            in_V;
  logic [LANES-1:0]            in_N;
  logic [LANES-1:0]            in_mask;
  logic [RDW-1:0]              in_rd;
  logic                        in_we;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][WIDTH-1:0] out_result;
  logic [RDW-1:0]              out_rd;
  logic                        out_we;
  logic                        out_C;
  logic                        out_V;
  logic                        out_N;
  logic                        sticky_clr;
  logic                        sticky_V;
  logic [CNTW-1:0]             ovf_count;

  // Second instance with a narrow counter so saturation is reachable.
  logic                        s_in_ready;
  logic                        s_out_valid;
  logic [LANES-1:0][WIDTH-1:0] s_out_result;
  logic [RDW-1:0]              s_out_rd;
  logic                        s_out_we;
  logic                        s_out_C;
  logic                        s_out_V;
  logic                        s_out_N;
  logic                        s_sticky_V;
  logic [3:0]                  s_ovf_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic         m_sticky;
  int           m_ovf;
  int           m_ovf4;

  vector_ex_wb_buffer #(.WIDTH(WIDTH), .LANES(LANES), .RDW(RDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_C(in_C), .in_V(in_V), .in_N(in_N), .in_mask(in_mask),
    .in_rd(in_rd), .in_we(in_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_C(out_C),
    .out_V(out_V), .out_N(out_N), .sticky_clr(sticky_clr), .sticky_V(sticky_V),
    .ovf_count(ovf_count)
  );

  vector_ex_wb_buffer #(.WIDTH(WIDTH), .LANES(LANES), .RDW(RDW), .CNTW(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .in_C(in_C), .in_V(in_V), .in_N(in_N), .in_mask(in_mask),
    .in_rd(in_rd), .in_we(in_we), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_rd(s_out_rd), .out_we(s_out_we), .out_C(s_out_C),
    .out_V(s_out_V), .out_N(s_out_N), .sticky_clr(sticky_clr), .sticky_V(s_sticky_V),
    .ovf_count(s_ovf_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] expect_entry();
    logic [LANES-1:0][WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (in_mask[i]) r[i] = in_result[i];
    return {r, in_rd, in_we, |(in_C & in_mask), |(in_V & in_mask), |(in_N & in_mask)};
  endfunction

  function automatic logic [W-1:0] head_seen();
    return {out_result, out_rd, out_we, out_C, out_V, out_N};
  endfunction

  // scoreboard: inputs and outputs are stable at the falling edge, ahead of the next rising edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         acc;
    int           pc;
    if (rst) begin
      exp_q.delete();
      m_sticky = 1'b0;
      m_ovf    = 0;
      m_ovf4   = 0;
    end else begin
      check_eq("in_ready", in_ready, exp_q.size() != 2);
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      check_eq("sticky_V", sticky_V, m_sticky);
      check_eq("ovf_count", ovf_count, m_ovf);
      check_eq("ovf_count_sat", s_ovf_count, m_ovf4);
      if (exp_q.size() != 0) check_eq("head", head_seen(), exp_q[0]);
      acc = in_valid && (exp_q.size() != 2) && !flush;
      e   = expect_entry();
      pc  = $countones(in_V & in_mask);
      if (flush) exp_q.delete();
      else begin
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
      end
      if (acc && pc != 0) m_sticky = 1'b1;
      else if (sticky_clr) m_sticky = 1'b0;
      if (acc) begin
        m_ovf  = (m_ovf + pc > 65535) ? 65535 : m_ovf + pc;
        m_ovf4 = (m_ovf4 + pc > 15) ? 15 : m_ovf4 + pc;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [LANES-1:0][WIDTH-1:0] res,
                        input logic [LANES-1:0] mask, input logic [LANES-1:0] vf,
                        input logic [LANES-1:0] nf, input logic [RDW-1:0] rd);
    in_valid  = v;
    in_result = res;
    in_mask   = mask;
    in_V      = vf;
    in_N      = nf;
    in_C      = 8'h00;
    in_rd     = rd;
    in_we     = 1'b1;
  endtask

  task automatic idle();
    set_in(1'b0, '0, 8'h00, 8'h00, 8'h00, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [LANES-1:0][WIDTH-1:0] seq;
    logic [LANES-1:0][WIDTH-1:0] pat_a;
    logic [LANES-1:0][WIDTH-1:0] pat_b;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    check_eq("rst_result", out_result, 0);
    check_eq("rst_rd_we_flags", {out_rd, out_we, out_C, out_V, out_N}, 0);
    check_eq("rst_ready", {in_ready, out_valid}, 2'b10);

    // pass-through
    for (int i = 0; i < LANES; i++) seq[i] = 8'(i + 1);
    out_ready = 1'b1;
    set_in(1'b1, seq, 8'hFF, 8'h00, 8'h00, 4'd3);
    step();
    idle();
    check_eq("pass_valid", out_valid, 1);
    check_eq("pass_result", out_result, 64'h0807060504030201);
    check_eq("pass_rd", out_rd, 3);
    step();
    check_eq("pass_drain", out_valid, 0);

    // backpressure / full
    pat_a = 64'hA1A2A3A4A5A6A7A8;
    pat_b = 64'hB1B2B3B4B5B6B7B8;
    out_ready = 1'b0;
    set_in(1'b1, pat_a, 8'hFF, 8'h00, 8'h00, 4'd1);
    step();
    set_in(1'b1, pat_b, 8'hFF, 8'h00, 8'h00, 4'd2);
    step();
    check_eq("full_ready", in_ready, 0);
    set_in(1'b1, 64'hC1C2C3C4C5C6C7C8, 8'hFF, 8'h00, 8'h00, 4'd7);
    step();
    idle();
    check_eq("stall_head_a", out_result, pat_a);
    out_ready = 1'b1;
    step();
    check_eq("pop_ready", in_ready, 1);
    check_eq("head_b", out_result, pat_b);
    step();
    check_eq("c_not_taken", out_valid, 0);

    // masking / flags
    set_in(1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 8'h30, 8'h01, 4'd5);
    step();
    idle();
    check_eq("mask_result", out_result, 64'h00000000FFFFFFFF);
    check_eq("mask_vn", {out_V, out_N}, 2'b01);
    check_eq("mask_status", {sticky_V, ovf_count}, 17'h0);
    step();

    // overflow accounting
    set_in(1'b1, seq, 8'hFF, 8'hFF, 8'h00, 4'd6);
    step();
    check_eq("ovf_set", {sticky_V, ovf_count}, {1'b1, 16'd8});
    sticky_clr = 1'b1;
    set_in(1'b1, seq, 8'hFF, 8'h01, 8'h00, 4'd6);
    step();
    check_eq("ovf_clr_set", {sticky_V, ovf_count}, {1'b1, 16'd9});
    idle();
    step();
    sticky_clr = 1'b0;
    check_eq("ovf_clr", sticky_V, 0);
    set_in(1'b1, seq, 8'hFF, 8'hFF, 8'h00, 4'd6);
    step();
    idle();
    check_eq("ovf_17", ovf_count, 17);
    check_eq("ovf_sat15", s_ovf_count, 15);
    set_in(1'b1, seq, 8'hFF, 8'hFF, 8'h00, 4'd6);
    step();
    idle();
    check_eq("ovf_sat_hold", s_ovf_count, 15);
    step();

    // flush while full with a push offered
    out_ready = 1'b0;
    set_in(1'b1, pat_a, 8'hFF, 8'h00, 8'h00, 4'd1);
    step();
    step();
    flush = 1'b1;
    set_in(1'b1, pat_b, 8'hFF, 8'hFF, 8'h00, 4'd9);
    step();
    flush = 1'b0;
    idle();
    check_eq("flush_state", {out_valid, in_ready}, 2'b01);
    check_eq("flush_ovf", ovf_count, 25);
    step();

    // reset mid-operation
    set_in(1'b1, pat_a, 8'hFF, 8'h01, 8'h00, 4'd1);
    step();
    step();
    idle();
    out_ready = 1'b1;
    do_reset();
    check_eq("mid_rst_out", {out_valid, in_ready, out_rd, out_we, out_C, out_V, out_N}, 10'b0100000000);
    check_eq("mid_rst_result", out_result, 0);
    check_eq("mid_rst_status", {sticky_V, ovf_count}, 17'h0);
    set_in(1'b1, pat_b, 8'hFF, 8'h00, 8'h00, 4'd4);
    step();
    idle();
    check_eq("post_rst_push", {out_valid, out_result}, {1'b1, pat_b});
    step();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [LANES-1:0][WIDTH-1:0] r;
      for (int i = 0; i < LANES; i++) r[i] = 8'($urandom_range(0, 255));
      set_in(1'($urandom_range(0, 1)), r, 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      in_C       = 8'($urandom_range(0, 255));
      in_we      = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    flush = 1'b0;
    sticky_clr = 1'b0;
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
